// File: rtl/mm_input_arbiter_if.sv
// Handshake and status bundle between the two packet sources, the input arbiter
// and the matching-memory (MMCAM) stage.
interface mm_input_arbiter_if #(
   parameter int PW   = 38,
   parameter int OCCW = 5
);
   logic            Send_in0;
   logic [PW-1:0]   PACKET_IN0;
   logic            Ack_out0;
   logic            Send_in1;
   logic [PW-1:0]   PACKET_IN1;
   logic            Ack_out1;
   logic            Send_out;
   logic [PW-1:0]   PACKET_OUT;
   logic            Ack_in;
   logic            WR_E;
   logic            DEL;
   logic            GRANT;
   logic [OCCW-1:0] OCC;
   logic            MM_FULL;
   logic            OCC_ERR;

   // Environment side: sources, MMCAM stage and its entry strobes.
   modport master (
      output Send_in0, PACKET_IN0, Send_in1, PACKET_IN1, Ack_in, WR_E, DEL,
      input  Ack_out0, Ack_out1, Send_out, PACKET_OUT, GRANT, OCC, MM_FULL, OCC_ERR
   );

   // Arbiter side.
   modport slave (
      input  Send_in0, PACKET_IN0, Send_in1, PACKET_IN1, Ack_in, WR_E, DEL,
      output Ack_out0, Ack_out1, Send_out, PACKET_OUT, GRANT, OCC, MM_FULL, OCC_ERR
   );
endinterface

// File: rtl/mm_input_arbiter.sv
// Two-source round-robin arbiter feeding the MMCAM stage over a 4-phase handshake,
// plus a status-only occupancy tracker driven by the stage's WR_E/DEL strobes.
module mm_input_arbiter #(
   parameter int PW      = 38,
   parameter int ENTRIES = 20,
   parameter int OCCW    = 5
) (
   input logic             CP,
   input logic             MR,
   mm_input_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SEND     = 2'd1,
      WAIT_LOW = 2'd2
   } state_t;

   localparam logic [OCCW-1:0] OCC_MAX = OCCW'(ENTRIES);

   state_t          state_q, state_d;
   logic [1:0]      ack_q;
   logic [1:0]      send_in;
   logic [1:0]      elig;
   logic            winner;
   logic            grant_fire;
   logic            grant_q;
   logic [PW-1:0]   packet_q;
   logic [OCCW-1:0] occ_q;
   logic            occ_err_q;

   // A source that is still being acknowledged stays out of arbitration, so a
   // held-high Send_in can never cause the same packet to be accepted twice.
   assign send_in = {bus.Send_in1, bus.Send_in0};
   assign elig    = send_in & ~ack_q;
   assign winner  = (elig == 2'b11) ? ~grant_q : elig[1];

   always_ff @(posedge CP) begin
      // NOTE: non-blocking assignments keep every register updating from pre-edge values.
      if (MR) state_q <= IDLE;
      else    state_q <= state_d;
   end

   always_comb begin
      // NOTE: defaults first so no path through the case leaves a signal unassigned (no latch).
      state_d    = state_q;
      grant_fire = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (|elig) begin
               grant_fire = 1'b1;
               state_d    = SEND;
            end
         end
         SEND:     if (bus.Ack_in)  state_d = WAIT_LOW;
         WAIT_LOW: if (!bus.Ack_in) state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   always_ff @(posedge CP) begin
      if (MR) begin
         packet_q <= '0;
         grant_q  <= 1'b1;
         ack_q    <= 2'b00;
      end else begin
         if (grant_fire) begin
            packet_q <= winner ? bus.PACKET_IN1 : bus.PACKET_IN0;
            grant_q  <= winner;
         end
         for (int x = 0; x < 2; x++) begin
            if (grant_fire && (winner == x[0]))
               ack_q[x] <= 1'b1;
            else if (ack_q[x] && !send_in[x])
               ack_q[x] <= 1'b0;
         end
      end
   end

   // Occupancy is reported only; MF packets may match and delete, so a full
   // memory must not stall arbitration.
   always_ff @(posedge CP) begin
      if (MR) begin
         occ_q     <= '0;
         occ_err_q <= 1'b0;
      end else if (bus.WR_E && !bus.DEL) begin
         if (occ_q < OCC_MAX) occ_q     <= occ_q + 1'b1;
         else                 occ_err_q <= 1'b1;
      end else if (bus.DEL && !bus.WR_E) begin
         if (occ_q != '0)     occ_q     <= occ_q - 1'b1;
         else                 occ_err_q <= 1'b1;
      end
   end

   assign bus.Send_out   = (state_q == SEND);
   assign bus.PACKET_OUT = packet_q;
   assign bus.Ack_out0   = ack_q[0];
   assign bus.Ack_out1   = ack_q[1];
   assign bus.GRANT      = grant_q;
   assign bus.OCC        = occ_q;
   assign bus.MM_FULL    = (occ_q == OCC_MAX);
   assign bus.OCC_ERR    = occ_err_q;

endmodule

// File: tb/tb_mm_input_arbiter.sv
// Scoreboard bench for mm_input_arbiter: expected deliveries are queued as stimulus
// is issued and a monitor checks each packet as the MMCAM request rises.
module tb_mm_input_arbiter;
   localparam int PW      = 38;
   localparam int ENTRIES = 20;
   localparam int OCCW    = 5;

   typedef struct {
      logic          src;
      logic [PW-1:0] pkt;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   mm_input_arbiter_if #(.PW(PW), .OCCW(OCCW)) bus ();

   mm_input_arbiter #(.PW(PW), .ENTRIES(ENTRIES), .OCCW(OCCW)) dut (
      .CP (clk),
      .MR (rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int   checks = 0;
   int   errors = 0;
   exp_t exp_q[$];
   bit   stage_auto = 1'b0;
   int   ack_delay  = 0;
   bit   gap_check  = 1'b0;
   int   last_rise  = -1;
   int   cyc        = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   task automatic timeout_fail(input string what);
      checks++;
      errors++;
      $display("FAIL %s timed out at cycle %0d", what, cyc);
   endtask

   function automatic logic ack_of(input bit s);
      return s ? bus.Ack_out1 : bus.Ack_out0;
   endfunction

   // One 4-phase transfer from source s; called at a negedge.
   task automatic src_send(input bit s, input logic [PW-1:0] pkt, input int hold);
      int n;
      if (s) begin bus.PACKET_IN1 = pkt; bus.Send_in1 = 1'b1; end
      else   begin bus.PACKET_IN0 = pkt; bus.Send_in0 = 1'b1; end
      n = 0;
      do begin @(negedge clk); n++; end while (ack_of(s) !== 1'b1 && n < 200);
      if (ack_of(s) !== 1'b1) timeout_fail(s ? "src1_ack_rise" : "src0_ack_rise");
      repeat (hold) @(negedge clk);
      if (hold > 0) check(s ? "src1_ack_held" : "src0_ack_held", ack_of(s), 1);
      if (s) bus.Send_in1 = 1'b0;
      else   bus.Send_in0 = 1'b0;
      n = 0;
      do begin @(negedge clk); n++; end while (ack_of(s) !== 1'b0 && n < 200);
      if (ack_of(s) !== 1'b0) timeout_fail(s ? "src1_ack_fall" : "src0_ack_fall");
   endtask

   task automatic do_reset();
      bus.Send_in0 = 1'b0;
      bus.Send_in1 = 1'b0;
      bus.WR_E     = 1'b0;
      bus.DEL      = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   // MMCAM stage model: raises Ack_in after ack_delay cycles of Send_out, drops it when Send_out falls.
   initial begin
      int hold_cnt;
      hold_cnt = 0;
      forever begin
         @(negedge clk);
         if (stage_auto) begin
            if (bus.Send_out) begin
               if (hold_cnt >= ack_delay) bus.Ack_in = 1'b1;
               else                       hold_cnt++;
            end else begin
               bus.Ack_in = 1'b0;
               hold_cnt   = 0;
            end
         end else begin
            hold_cnt = 0;
         end
      end
   end

   // Monitor: every rising Send_out must deliver the next queued packet.
   initial begin
      logic prev;
      exp_t e;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         cyc++;
         if (bus.Send_out === 1'b1 && prev !== 1'b1) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_packet got %0h want none at cycle %0d", bus.PACKET_OUT, cyc);
            end else begin
               e = exp_q.pop_front();
               check("packet_out", bus.PACKET_OUT, e.pkt);
               check("grant", bus.GRANT, e.src);
            end
            if (gap_check && last_rise >= 0) check("packet_gap", cyc - last_rise, 3);
            last_rise = cyc;
         end
         prev = bus.Send_out;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [PW-1:0] p;
      int n;
      bus.Send_in0 = 1'b0; bus.PACKET_IN0 = '0;
      bus.Send_in1 = 1'b0; bus.PACKET_IN1 = '0;
      bus.Ack_in   = 1'b0;
      bus.WR_E     = 1'b0;
      bus.DEL      = 1'b0;
      repeat (2) @(negedge clk);
      do_reset();

      // 1. Reset state, then an Ack_in pulse in IDLE must not start a transfer.
      check("rst_send_out", bus.Send_out, 0);
      check("rst_ack0", bus.Ack_out0, 0);
      check("rst_ack1", bus.Ack_out1, 0);
      check("rst_packet", bus.PACKET_OUT, 0);
      check("rst_grant", bus.GRANT, 1);
      check("rst_occ", bus.OCC, 0);
      check("rst_full", bus.MM_FULL, 0);
      check("rst_err", bus.OCC_ERR, 0);
      bus.Ack_in = 1'b1;
      @(negedge clk);
      bus.Ack_in = 1'b0;
      check("idle_ack_ignored", bus.Send_out, 0);
      @(negedge clk);
      check("idle_ack_ignored2", bus.Send_out, 0);

      // 2. Source 0 alone, stage acknowledges after two cycles.
      stage_auto = 1'b1;
      ack_delay  = 2;
      p = 38'h2A_AAAA_AAAA;
      bus.PACKET_IN0 = p;
      bus.Send_in0   = 1'b1;
      exp_q.push_back('{1'b0, p});
      @(negedge clk);
      check("t2_send_out", bus.Send_out, 1);
      check("t2_ack0", bus.Ack_out0, 1);
      check("t2_packet", bus.PACKET_OUT, p);
      bus.Send_in0 = 1'b0;
      n = 0;
      while (bus.Send_out === 1'b1 && n < 20) begin @(negedge clk); n++; end
      if (bus.Send_out !== 1'b0) timeout_fail("t2_send_out_fall");
      check("t2_ack0_released", bus.Ack_out0, 0);
      repeat (2) @(negedge clk);
      check("t2_back_idle", bus.Send_out, 0);

      // 3. Both sources stream three packets each into a zero-delay stage.
      do_reset();
      ack_delay = 0;
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back('{1'b0, 38'h00_1000_0000 + PW'(i)});
         exp_q.push_back('{1'b1, 38'h3F_2000_0000 + PW'(i)});
      end
      last_rise = -1;
      gap_check = 1'b1;
      fork
         begin
            for (int i = 0; i < 3; i++) src_send(1'b0, 38'h00_1000_0000 + PW'(i), 0);
         end
         begin
            for (int i = 0; i < 3; i++) src_send(1'b1, 38'h3F_2000_0000 + PW'(i), 0);
         end
      join
      repeat (3) @(negedge clk);
      gap_check = 1'b0;
      check("t3_all_delivered", exp_q.size(), 0);

      // 4. Source 1 holds its request after acknowledge; source 0 is served meanwhile.
      exp_q.push_back('{1'b1, 38'h15_5555_0001});
      exp_q.push_back('{1'b0, 38'h0C_0000_00D0});
      exp_q.push_back('{1'b0, 38'h0C_0000_00D1});
      fork
         src_send(1'b1, 38'h15_5555_0001, 10);
         begin
            repeat (2) @(negedge clk);
            src_send(1'b0, 38'h0C_0000_00D0, 0);
            src_send(1'b0, 38'h0C_0000_00D1, 0);
         end
      join
      repeat (4) @(negedge clk);
      check("t4_all_delivered", exp_q.size(), 0);

      // 5. Occupancy saturation, simultaneous strobes and underflow.
      bus.WR_E = 1'b1;
      repeat (19) @(negedge clk);
      check("occ_19", bus.OCC, 19);
      check("full_at_19", bus.MM_FULL, 0);
      @(negedge clk);
      check("occ_20", bus.OCC, 20);
      check("full_at_20", bus.MM_FULL, 1);
      check("err_at_20", bus.OCC_ERR, 0);
      @(negedge clk);
      bus.WR_E = 1'b0;
      check("occ_overflow_hold", bus.OCC, 20);
      check("err_overflow", bus.OCC_ERR, 1);
      bus.WR_E = 1'b1;
      bus.DEL  = 1'b1;
      @(negedge clk);
      bus.WR_E = 1'b0;
      check("occ_wr_del", bus.OCC, 20);
      repeat (20) @(negedge clk);
      check("occ_drained", bus.OCC, 0);
      check("full_drained", bus.MM_FULL, 0);
      @(negedge clk);
      bus.DEL = 1'b0;
      check("occ_underflow_hold", bus.OCC, 0);
      check("err_sticky", bus.OCC_ERR, 1);

      // 6. Reset while in SEND and while in WAIT_LOW.
      do_reset();
      stage_auto = 1'b0;
      bus.Ack_in = 1'b0;
      bus.WR_E   = 1'b1;
      repeat (3) @(negedge clk);
      bus.WR_E = 1'b0;
      check("t6_occ_pre", bus.OCC, 3);
      bus.PACKET_IN0 = 38'h12_3456_789A;
      bus.Send_in0   = 1'b1;
      exp_q.push_back('{1'b0, 38'h12_3456_789A});
      @(negedge clk);
      check("t6_in_send", bus.Send_out, 1);
      rst = 1'b1;
      bus.Send_in0 = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      check("t6a_send_out", bus.Send_out, 0);
      check("t6a_ack0", bus.Ack_out0, 0);
      check("t6a_occ", bus.OCC, 0);
      check("t6a_packet", bus.PACKET_OUT, 0);
      check("t6a_grant", bus.GRANT, 1);

      bus.PACKET_IN1 = 38'h21_0FED_CBA9;
      bus.Send_in1   = 1'b1;
      exp_q.push_back('{1'b1, 38'h21_0FED_CBA9});
      @(negedge clk);
      check("t6b_in_send", bus.Send_out, 1);
      bus.Ack_in = 1'b1;
      @(negedge clk);
      check("t6b_in_wait_low", bus.Send_out, 0);
      check("t6b_ack1_pre", bus.Ack_out1, 1);
      rst = 1'b1;
      bus.Send_in1 = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      check("t6b_send_out", bus.Send_out, 0);
      check("t6b_ack0", bus.Ack_out0, 0);
      check("t6b_ack1", bus.Ack_out1, 0);
      check("t6b_occ", bus.OCC, 0);
      check("t6b_packet", bus.PACKET_OUT, 0);
      // Ack_in is still high: only an IDLE FSM can grant on the next edge.
      bus.PACKET_IN0 = 38'h01_1111_2222;
      bus.Send_in0   = 1'b1;
      exp_q.push_back('{1'b0, 38'h01_1111_2222});
      @(negedge clk);
      check("t6b_idle_after_rst", bus.Send_out, 1);
      bus.Send_in0 = 1'b0;
      @(negedge clk);
      bus.Ack_in = 1'b0;
      repeat (3) @(negedge clk);
      check("t6_final_idle", bus.Send_out, 0);
      check("queue_drained", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
